// File: rtl/video_lock_ctrl.sv
`timescale 1ns/1ps
// Video format lock controller: measures HS period, DE width and line count,
// qualifies the format over several frames and drives a frame-aligned enable.
module video_lock_ctrl #(
    parameter int H_WIDTH     = 1920,
    parameter int H_TOTAL     = 2200,
    parameter int V_HEIGHT    = 1080,
    parameter int LOCK_FRAMES = 4,
    parameter int CW          = 12
) (
    input  logic       vin_clk_i,
    input  logic       vin_rst_ni,
    input  logic       vin_hs_i,
    input  logic       vin_vs_i,
    input  logic       vin_de_i,
    output logic       locked_o,
    output logic       process_en_o,
    output logic [1:0] state_o,
    output logic       frame_o,
    output logic [7:0] loss_cnt_o
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW:0]   H_TOT_C   = (CW+1)'(H_TOTAL);
    localparam logic [CW-1:0] H_WID_C   = CW'(H_WIDTH);
    localparam logic [CW-1:0] V_HGT_C   = CW'(V_HEIGHT);
    localparam logic [3:0]    LOCK_C    = 4'(LOCK_FRAMES);

    // Async assert, clock-synchronous release
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge vin_clk_i or negedge vin_rst_ni) begin
        if (!vin_rst_ni) r_rst_sync <= '0;
        else             r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic          r_hs_q, r_vs_q, r_de_q;
    logic [CW-1:0] r_h_cnt, r_de_cnt, r_v_cnt;
    logic          r_h_seen, r_frame_bad;

    logic          w_hs_rise, w_vs_rise, w_de_fall, w_wdog;
    logic          w_h_err, w_de_err, w_line_err, w_frame_good;
    logic [CW-1:0] w_v_inc, w_v_end;

    assign w_hs_rise  = vin_hs_i & ~r_hs_q;
    assign w_vs_rise  = vin_vs_i & ~r_vs_q;
    assign w_de_fall  = ~vin_de_i & r_de_q;
    assign w_wdog     = (r_h_cnt == CNT_MAX);
    assign w_h_err    = w_hs_rise & r_h_seen
                      & (({1'b0, r_h_cnt} + (CW+1)'(1)) != H_TOT_C);
    assign w_de_err   = w_de_fall & (r_de_cnt != H_WID_C);
    assign w_line_err = w_h_err | w_de_err;
    assign w_v_inc    = (r_v_cnt == CNT_MAX) ? r_v_cnt : r_v_cnt + CW'(1);
    // A DE fall on the VS-rise cycle still belongs to the ending frame
    assign w_v_end    = w_de_fall ? w_v_inc : r_v_cnt;
    assign w_frame_good = ~r_frame_bad & ~w_line_err & (w_v_end == V_HGT_C);

    always_ff @(posedge vin_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hs_q      <= 1'b0;
            r_vs_q      <= 1'b0;
            r_de_q      <= 1'b0;
            r_h_cnt     <= '0;
            r_de_cnt    <= '0;
            r_v_cnt     <= '0;
            r_h_seen    <= 1'b0;
            r_frame_bad <= 1'b0;
        end else begin
            r_hs_q <= vin_hs_i;
            r_vs_q <= vin_vs_i;
            r_de_q <= vin_de_i;
            if (w_hs_rise)    r_h_cnt <= '0;
            else if (!w_wdog) r_h_cnt <= r_h_cnt + CW'(1);
            if (w_wdog)         r_h_seen <= 1'b0;
            else if (w_hs_rise) r_h_seen <= 1'b1;
            if (w_de_fall)
                r_de_cnt <= '0;
            else if (vin_de_i && r_de_cnt != CNT_MAX)
                r_de_cnt <= r_de_cnt + CW'(1);
            if (w_vs_rise) begin
                r_v_cnt     <= '0;
                r_frame_bad <= 1'b0;
            end else begin
                r_v_cnt     <= w_v_end;
                r_frame_bad <= r_frame_bad | w_line_err;
            end
        end
    end

    state_t     r_state, w_state_nxt;
    logic [3:0] r_good_cnt, w_good_nxt, w_good_inc;
    logic       r_pen, w_pen_nxt, w_loss_evt;
    logic       r_locked, r_frame;
    logic [7:0] r_loss;

    assign w_good_inc = r_good_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_pen_nxt   = r_pen;
        w_loss_evt  = 1'b0;
        if (w_wdog) begin
            w_state_nxt = ST_SEARCH;
            w_good_nxt  = '0;
            w_pen_nxt   = 1'b0;
            w_loss_evt  = (r_state == ST_LOCKED);
        end else begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_vs_rise) begin
                        w_state_nxt = ST_CHECK;
                        w_good_nxt  = '0;
                    end
                end
                ST_CHECK: begin
                    if (w_vs_rise && w_frame_good) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == LOCK_C) w_state_nxt = ST_LOCKED;
                    end else if (w_vs_rise) begin
                        w_good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_line_err || (w_vs_rise && !w_frame_good)) begin
                        w_state_nxt = ST_CHECK;
                        w_good_nxt  = '0;
                        w_pen_nxt   = 1'b0;
                        w_loss_evt  = 1'b1;
                    end else if (w_vs_rise) begin
                        w_pen_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                    w_good_nxt  = '0;
                    w_pen_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge vin_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= '0;
            r_pen      <= 1'b0;
            r_locked   <= 1'b0;
            r_frame    <= 1'b0;
            r_loss     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_pen      <= w_pen_nxt;
            r_locked   <= (w_state_nxt == ST_LOCKED);
            r_frame    <= w_vs_rise;
            if (w_loss_evt && r_loss != 8'hFF) r_loss <= r_loss + 8'd1;
        end
    end

    assign locked_o     = r_locked;
    assign process_en_o = r_pen;
    assign state_o      = r_state;
    assign frame_o      = r_frame;
    assign loss_cnt_o   = r_loss;

endmodule
